// File: rtl/bounce_pkg.sv
// Shared definitions for the bounce motion engine: FSM state encoding,
// LFSR constants and default display/sprite geometry.
package bounce_pkg;

  // Default geometry: 640x480 display with 128x128 sprites.
  localparam int DEF_DISP_W = 640;
  localparam int DEF_DISP_H = 480;
  localparam int DEF_OBJ_W  = 128;
  localparam int DEF_OBJ_H  = 128;

  // FSM state encoding (plain constants for compatibility with older blocks).
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_UPDATE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; taps are bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] state);
    return ^(state & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/bounce_motion_engine_axis.sv
// Single-axis step/reflect: moves position p by step s in direction d and
// reflects off 0 and m. Purely combinational; instantiated once per axis.
module bounce_axis
  import bounce_pkg::*;
#(
  parameter int POS_W  = 10,
  parameter int STEP_W = 3
) (
  input  logic [POS_W-1:0]  p,
  input  logic [STEP_W-1:0] s,
  input  logic              d,
  input  logic [POS_W-1:0]  m,
  output logic [POS_W-1:0]  p_nxt,
  output logic              d_nxt,
  output logic              hit
);

  // One extra bit on the sum so p+s can never wrap past m unnoticed.
  logic [POS_W-1:0] s_pos;
  logic [POS_W:0]   sum;
  logic [POS_W-1:0] diff;

  assign s_pos = POS_W'(s);
  assign sum   = {1'b0, p} + {1'b0, s_pos};
  assign diff  = p - s_pos;

  // Reflect at either edge; a zero step freezes the object without bouncing.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    p_nxt = p;
    d_nxt = d;
    hit   = 1'b0;
    if (s != '0) begin
      if (d) begin
        if (sum >= {1'b0, m}) begin
          p_nxt = m;
          d_nxt = 1'b0;
          hit   = 1'b1;
        end else begin
          p_nxt = sum[POS_W-1:0];
        end
      end else if (p <= s_pos) begin
        p_nxt = '0;
        d_nxt = 1'b1;
        hit   = 1'b1;
      end else begin
        p_nxt = diff;
      end
    end
  end

endmodule

// File: rtl/bounce_motion_engine.sv
// Time-multiplexed N-object bounce engine. Once per frame_tick it walks the
// objects one per cycle through a shared pair of axis units, reflecting them
// off the display edges and bumping their colour index on each bounce.
// Optional feature: define BOUNCE_LFSR_EN to re-randomise an object's step
// from a 16-bit LFSR whenever it bounces.
module bounce_motion_engine
  import bounce_pkg::*;
#(
  parameter int NUM_OBJ  = 4,
  parameter int DISP_W   = DEF_DISP_W,
  parameter int DISP_H   = DEF_DISP_H,
  parameter int OBJ_W    = DEF_OBJ_W,
  parameter int OBJ_H    = DEF_OBJ_H,
  parameter int POS_W    = 10,
  parameter int STEP_W   = 3,
  parameter int CIDX_W   = 3,
  localparam int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [IDX_W-1:0]          ld_idx,
  input  logic [POS_W-1:0]          ld_x,
  input  logic [POS_W-1:0]          ld_y,
  input  logic                      ld_dirx,
  input  logic                      ld_diry,
  input  logic [STEP_W-1:0]         ld_step,
  output logic [NUM_OBJ*POS_W-1:0]  obj_x,
  output logic [NUM_OBJ*POS_W-1:0]  obj_y,
  output logic [NUM_OBJ*CIDX_W-1:0] obj_cidx,
  output logic [NUM_OBJ-1:0]        bounce,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int XMAX_I = DISP_W - OBJ_W;
  localparam int YMAX_I = DISP_H - OBJ_H;
  localparam logic [POS_W-1:0] XMAX = POS_W'(XMAX_I);
  localparam logic [POS_W-1:0] YMAX = POS_W'(YMAX_I);

  // Reset placement: objects fan out diagonally, clamped to the visible area.
  function automatic logic [POS_W-1:0] init_x(input int i);
    int v;
    v = i * OBJ_W / 2;
    if (v > XMAX_I) v = XMAX_I;
    return POS_W'(v);
  endfunction

  function automatic logic [POS_W-1:0] init_y(input int i);
    int v;
    v = i * OBJ_H / 4;
    if (v > YMAX_I) v = YMAX_I;
    return POS_W'(v);
  endfunction

  state_t             state;
  logic [IDX_W-1:0]   cnt;
  logic               pending;

  logic [POS_W-1:0]   x_q    [NUM_OBJ];
  logic [POS_W-1:0]   y_q    [NUM_OBJ];
  logic               dx_q   [NUM_OBJ];
  logic               dy_q   [NUM_OBJ];
  logic [STEP_W-1:0]  step_q [NUM_OBJ];
  logic [CIDX_W-1:0]  cidx_q [NUM_OBJ];

  logic [POS_W-1:0]   nx, ny;
  logic               ndx, ndy, hit_x, hit_y, hit_any;
  logic [STEP_W-1:0]  new_step;
  logic               ld_fire, ld_idx_ok, last_obj;

  assign ld_ready  = (state == ST_IDLE) && !frame_tick && !pending;
  assign ld_fire   = ld_valid && ld_ready;
  assign ld_idx_ok = ({1'b0, ld_idx} < (IDX_W+1)'(NUM_OBJ));
  assign last_obj  = (cnt == IDX_W'(NUM_OBJ - 1));
  assign hit_any   = hit_x || hit_y;

  bounce_axis #(.POS_W(POS_W), .STEP_W(STEP_W)) u_axis_x (
    .p     (x_q[cnt]),
    .s     (step_q[cnt]),
    .d     (dx_q[cnt]),
    .m     (XMAX),
    .p_nxt (nx),
    .d_nxt (ndx),
    .hit   (hit_x)
  );

  bounce_axis #(.POS_W(POS_W), .STEP_W(STEP_W)) u_axis_y (
    .p     (y_q[cnt]),
    .s     (step_q[cnt]),
    .d     (dy_q[cnt]),
    .m     (YMAX),
    .p_nxt (ny),
    .d_nxt (ndy),
    .hit   (hit_y)
  );

`ifdef BOUNCE_LFSR_EN
  logic [15:0] lfsr;

  // Free-running LFSR supplying a fresh step on each bounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_feedback(lfsr)};
  end

  assign new_step = (lfsr[STEP_W-1:0] == '0) ? STEP_W'(1) : lfsr[STEP_W-1:0];
`else
  assign new_step = step_q[cnt];
`endif

  // Frame sequencer, tick queueing, host loads and per-object update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bounce     <= '0;
      // NOTE: the object arrays are reset because they carry defined start positions, not just data.
      for (int i = 0; i < NUM_OBJ; i++) begin
        x_q[i]    <= init_x(i);
        y_q[i]    <= init_y(i);
        dx_q[i]   <= 1'b1;
        dy_q[i]   <= 1'b1;
        step_q[i] <= STEP_W'(1);
        cidx_q[i] <= CIDX_W'(i);
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      frame_done <= 1'b0;
      bounce     <= '0;
      if (frame_tick && pending) overrun <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_tick || pending) begin
            state   <= ST_UPDATE;
            cnt     <= '0;
            busy    <= 1'b1;
            pending <= 1'b0;
          end else if (ld_fire && ld_idx_ok) begin
            x_q[ld_idx]    <= (ld_x > XMAX) ? XMAX : ld_x;
            y_q[ld_idx]    <= (ld_y > YMAX) ? YMAX : ld_y;
            dx_q[ld_idx]   <= ld_dirx;
            dy_q[ld_idx]   <= ld_diry;
            step_q[ld_idx] <= ld_step;
          end
        end

        ST_UPDATE: begin
          if (frame_tick) pending <= 1'b1;
          x_q[cnt]    <= nx;
          y_q[cnt]    <= ny;
          dx_q[cnt]   <= ndx;
          dy_q[cnt]   <= ndy;
          bounce[cnt] <= hit_any;
          if (hit_any) begin
            cidx_q[cnt] <= cidx_q[cnt] + CIDX_W'(1);
            step_q[cnt] <= new_step;
          end
          if (last_obj) begin
            state      <= ST_DONE;
            frame_done <= 1'b1;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end

        ST_DONE: begin
          if (frame_tick) pending <= 1'b1;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Flatten the per-object registers onto the compositor-facing buses.
  for (genvar k = 0; k < NUM_OBJ; k++) begin : g_out
    assign obj_x[k*POS_W +: POS_W]      = x_q[k];
    assign obj_y[k*POS_W +: POS_W]      = y_q[k];
    assign obj_cidx[k*CIDX_W +: CIDX_W] = cidx_q[k];
  end

endmodule

// File: tb/tb_bounce_motion_engine.sv
// Self-checking bench for bounce_motion_engine (default build) against a
// behavioural model of the object motion rules.
module tb_bounce_motion_engine;

  localparam int NUM_OBJ = 4;
  localparam int POS_W   = 10;
  localparam int STEP_W  = 3;
  localparam int CIDX_W  = 3;
  localparam int XMAX    = 640 - 128;
  localparam int YMAX    = 480 - 128;
  localparam int IDX_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      frame_tick = 1'b0;
  logic                      ld_valid = 1'b0;
  logic                      ld_ready;
  logic [IDX_W-1:0]          ld_idx = '0;
  logic [POS_W-1:0]          ld_x = '0, ld_y = '0;
  logic                      ld_dirx = 1'b0, ld_diry = 1'b0;
  logic [STEP_W-1:0]         ld_step = '0;
  logic [NUM_OBJ*POS_W-1:0]  obj_x, obj_y;
  logic [NUM_OBJ*CIDX_W-1:0] obj_cidx;
  logic [NUM_OBJ-1:0]        bounce;
  logic                      busy, frame_done, overrun;

  bounce_motion_engine #(
    .NUM_OBJ(NUM_OBJ), .DISP_W(640), .DISP_H(480), .OBJ_W(128), .OBJ_H(128),
    .POS_W(POS_W), .STEP_W(STEP_W), .CIDX_W(CIDX_W)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_idx(ld_idx),
    .ld_x(ld_x), .ld_y(ld_y), .ld_dirx(ld_dirx), .ld_diry(ld_diry), .ld_step(ld_step),
    .obj_x(obj_x), .obj_y(obj_y), .obj_cidx(obj_cidx),
    .bounce(bounce), .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state per object.
  int mx[NUM_OBJ], my[NUM_OBJ], ms[NUM_OBJ], mc[NUM_OBJ];
  bit mdx[NUM_OBJ], mdy[NUM_OBJ], mhit[NUM_OBJ];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_OBJ; i++) begin
      mx[i]  = (i * 64 > XMAX) ? XMAX : i * 64;
      my[i]  = (i * 32 > YMAX) ? YMAX : i * 32;
      mdx[i] = 1'b1;
      mdy[i] = 1'b1;
      ms[i]  = 1;
      mc[i]  = i % 8;
    end
  endtask

  // Move p by s toward d and reflect off 0 / m.
  task automatic axis_ref(input int p, input int s, input bit d, input int m,
                          output int pn, output bit dn, output bit hit);
    pn = p; dn = d; hit = 1'b0;
    if (s != 0) begin
      if (d && p + s >= m)  begin pn = m; dn = 1'b0; hit = 1'b1; end
      else if (d)           pn = p + s;
      else if (p <= s)      begin pn = 0; dn = 1'b1; hit = 1'b1; end
      else                  pn = p - s;
    end
  endtask

  task automatic model_frame();
    int nx, ny;
    bit ndx, ndy, hx, hy;
    for (int k = 0; k < NUM_OBJ; k++) begin
      axis_ref(mx[k], ms[k], mdx[k], XMAX, nx, ndx, hx);
      axis_ref(my[k], ms[k], mdy[k], YMAX, ny, ndy, hy);
      mx[k] = nx; my[k] = ny; mdx[k] = ndx; mdy[k] = ndy;
      mhit[k] = hx | hy;
      if (hx | hy) mc[k] = (mc[k] + 1) % 8;
    end
  endtask

  task automatic model_load(input int idx, input int x, input int y, input bit dx,
                            input bit dy, input int s);
    if (idx < NUM_OBJ) begin
      mx[idx] = (x > XMAX) ? XMAX : x;
      my[idx] = (y > YMAX) ? YMAX : y;
      mdx[idx] = dx; mdy[idx] = dy; ms[idx] = s;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NUM_OBJ; k++) begin
      check($sformatf("%s_x%0d", tag, k), 32'(obj_x[k*POS_W +: POS_W]), mx[k]);
      check($sformatf("%s_y%0d", tag, k), 32'(obj_y[k*POS_W +: POS_W]), my[k]);
      check($sformatf("%s_c%0d", tag, k), 32'(obj_cidx[k*CIDX_W +: CIDX_W]), mc[k]);
    end
  endtask

  task automatic set_load(input int idx, input int x, input int y, input bit dx,
                          input bit dy, input int s);
    ld_idx = IDX_W'(idx); ld_x = POS_W'(x); ld_y = POS_W'(y);
    ld_dirx = dx; ld_diry = dy; ld_step = STEP_W'(s);
  endtask

  task automatic do_load(input int idx, input int x, input int y, input bit dx,
                         input bit dy, input int s);
    @(negedge clk);
    set_load(idx, x, y, dx, dy, s);
    ld_valid = 1'b1;
    #1 check("ld_ready_idle", 32'(ld_ready), 1);
    @(negedge clk);
    ld_valid = 1'b0;
    model_load(idx, x, y, dx, dy, s);
    check_all("load");
  endtask

  // One full update pass with cycle-accurate checks; optionally holds a load
  // request (prepared with set_load) from the first UPDATE cycle onwards.
  task automatic run_frame(input bit hold_load);
    logic [31:0] exp_b;
    @(negedge clk);
    frame_tick = 1'b1;
    model_frame();
    #1 check("ld_ready_tick", 32'(ld_ready), 0);
    for (int j = 0; j <= NUM_OBJ; j++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (hold_load && j == 0) ld_valid = 1'b1;
      #1;
      exp_b = (j >= 1 && mhit[j-1]) ? (32'd1 << (j - 1)) : 32'd0;
      check("busy", 32'(busy), 1);
      check("ld_ready_busy", 32'(ld_ready), 0);
      check($sformatf("bounce_c%0d", j), 32'(bounce), exp_b);
      check($sformatf("frame_done_c%0d", j), 32'(frame_done), (j == NUM_OBJ) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    check("busy_end", 32'(busy), 0);
    check("frame_done_end", 32'(frame_done), 0);
    check("bounce_end", 32'(bounce), 0);
    check_all("frame");
    if (hold_load) begin
      check("ld_ready_after", 32'(ld_ready), 1);
      @(negedge clk);
      ld_valid = 1'b0;
      model_load(int'(ld_idx), int'(ld_x), int'(ld_y), ld_dirx, ld_diry, int'(ld_step));
      check_all("held_load");
    end
  endtask

  initial begin
    int nd;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_ld_ready", 32'(ld_ready), 1);
    check("rst_x1", 32'(obj_x[POS_W +: POS_W]), 64);
    check("rst_y1", 32'(obj_y[POS_W +: POS_W]), 32);
    check("rst_c1", 32'(obj_cidx[CIDX_W +: CIDX_W]), 1);
    check_all("rst");

    // Right-edge bounce, then travel back.
    do_load(0, 511, 0, 1'b1, 1'b1, 1);
    run_frame(1'b0);
    check("edge_x0", 32'(obj_x[POS_W-1:0]), 512);
    run_frame(1'b0);
    check("edge_back_x0", 32'(obj_x[POS_W-1:0]), 511);

    // Corner hit: both axes bounce, colour advances once.
    do_load(0, 1, 1, 1'b0, 1'b0, 3);
    run_frame(1'b0);

    // Load held during an update, clamped on acceptance.
    set_load(3, 700, 400, 1'b0, 1'b1, 2);
    run_frame(1'b1);
    check("clamp_x3", 32'(obj_x[3*POS_W +: POS_W]), 512);
    check("clamp_y3", 32'(obj_y[3*POS_W +: POS_W]), 352);

    // Zero step freezes an object at an edge.
    do_load(2, 0, 352, 1'b0, 1'b1, 0);
    run_frame(1'b0);

    // Randomised loads and frames.
    for (int it = 0; it < 40; it++) begin
      nd = $urandom_range(0, 2);
      for (int l = 0; l < nd; l++)
        do_load($urandom_range(0, NUM_OBJ - 1), $urandom_range(0, 1023),
                $urandom_range(0, 1023), 1'($urandom), 1'($urandom),
                $urandom_range(0, 7));
      run_frame(1'b0);
    end
    check("no_overrun_yet", 32'(overrun), 0);

    // Tick while busy -> queued second pass; third tick -> overrun.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      if (frame_done) nd++;
      @(negedge clk);
    end
    model_frame();
    model_frame();
    check("two_passes", 32'(nd), 2);
    check("overrun_set", 32'(overrun), 1);
    check("busy_idle", 32'(busy), 0);
    check_all("double");

    // Reset in the middle of an update pass.
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1 check("midrst_busy", 32'(busy), 0);
    check_all("midrst");
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < NUM_OBJ + 4; c++) begin
      @(negedge clk);
      if (frame_done || busy) nd++;
    end
    check("midrst_no_done", 32'(nd), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check_all("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
